// File: rtl/serial_sub_pkg.sv
// Shared definitions for the serial subtractor: FSM state encoding and
// an elaboration-time parameter sanity helper.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic bit bpc_divides(input int width, input int bpc);
        return (bpc > 0) && (bpc <= width) && ((width % bpc) == 0);
    endfunction

endpackage

// File: rtl/serial_sub_full_sub_cell.sv
// Single-bit full subtractor: d = a - b - bin, bo = borrow out.
module full_sub_cell (
    output logic d,
    output logic bo,
    input  logic a,
    input  logic b,
    input  logic bin
);

    assign d  = a ^ b ^ bin;
    assign bo = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub.sv
// Multi-cycle subtractor: a - b - bin over WIDTH bits, BPC bits per clock,
// LSB first, with registered difference, borrow-out and signed overflow.
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int BPC   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int STEPS = WIDTH / BPC;
    localparam int CNT_W = $clog2(STEPS + 1);

    if (WIDTH < 2 || !bpc_divides(WIDTH, BPC)) begin : g_param_check
        $error("serial_sub: WIDTH must be >= 2 and divisible by BPC");
    end

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] diff_sr;
    logic             borrow_r;
    logic [CNT_W-1:0] step_cnt;
    logic             a_msb;
    logic             b_msb;

    logic [BPC:0]         chain;
    logic [BPC-1:0]       step_d;
    logic [WIDTH+BPC-1:0] diff_cat;
    logic [WIDTH-1:0]     diff_next;
    logic                 last_step;
    logic                 accept;

    // Borrow ripples LSB to MSB through the BPC cells of one step.
    assign chain[0] = borrow_r;

    for (genvar i = 0; i < BPC; i++) begin : g_cells
        full_sub_cell u_cell (
            .d   (step_d[i]),
            .bo  (chain[i+1]),
            .a   (a_sr[i]),
            .b   (b_sr[i]),
            .bin (chain[i])
        );
    end

    // New result bits enter from the MSB side; the concatenation avoids a
    // zero-width slice when BPC equals WIDTH.
    assign diff_cat  = {step_d, diff_sr};
    assign diff_next = diff_cat[WIDTH+BPC-1:BPC];
    assign last_step = (step_cnt == CNT_W'(STEPS - 1));
    assign accept    = start && ((state == S_IDLE) || (state == S_DONE));

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_RUN;
            S_RUN:   if (last_step) state_next = S_DONE;
            S_DONE:  state_next = start ? S_RUN : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs are loaded on the final RUN edge so they are valid during DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sr     <= '0;
            b_sr     <= '0;
            diff_sr  <= '0;
            borrow_r <= 1'b0;
            step_cnt <= '0;
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            diff     <= '0;
            bout     <= 1'b0;
            ovf      <= 1'b0;
        end else if (accept) begin
            a_sr     <= a;
            b_sr     <= b;
            borrow_r <= bin;
            step_cnt <= '0;
            a_msb    <= a[WIDTH-1];
            b_msb    <= b[WIDTH-1];
        end else if (state == S_RUN) begin
            a_sr     <= a_sr >> BPC;
            b_sr     <= b_sr >> BPC;
            diff_sr  <= diff_next;
            borrow_r <= chain[BPC];
            step_cnt <= step_cnt + CNT_W'(1);
            if (last_step) begin
                diff <= diff_next;
                bout <= chain[BPC];
                ovf  <= (a_msb ^ b_msb) & (a_msb ^ diff_next[WIDTH-1]);
            end
        end
    end

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub: one 8-bit/1-bpc and one 16-bit/4-bpc
// instance, table vectors, random vectors against an arithmetic model, corner sequences.
module tb_serial_sub;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start8, start16;
    logic [7:0]  a8, b8;
    logic [15:0] a16, b16;
    logic        bin8, bin16;
    logic        busy8, done8, bout8, ovf8;
    logic        busy16, done16, bout16, ovf16;
    logic [7:0]  diff8;
    logic [15:0] diff16;

    serial_sub #(.WIDTH(8), .BPC(1)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .ovf(ovf8)
    );

    serial_sub #(.WIDTH(16), .BPC(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .bin(bin16),
        .busy(busy16), .done(done16), .diff(diff16), .bout(bout16), .ovf(ovf16)
    );

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        bit          wide;
        logic [15:0] a;
        logic [15:0] b;
        bit          bin;
        logic [15:0] d;
        bit          bo;
        bit          ov;
    } vec_t;

    vec_t tbl[5];

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Arithmetic reference: plain integer subtraction and signed range test.
    function automatic void refModel(input bit wide, input logic [15:0] a, input logic [15:0] b,
                                     input bit bin, output logic [15:0] d, output bit bo, output bit ov);
        int     w;
        longint mask, ua, ub, half, sa, sb, sr;
        w    = wide ? 16 : 8;
        mask = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        ua   = longint'(a) & mask;
        ub   = longint'(b) & mask;
        d    = 16'((ua - ub - longint'(bin)) & mask);
        bo   = (ua < ub + longint'(bin));
        sa   = (ua >= half) ? ua - (longint'(1) << w) : ua;
        sb   = (ub >= half) ? ub - (longint'(1) << w) : ub;
        sr   = sa - sb - longint'(bin);
        ov   = (sr < -half) || (sr >= half);
    endfunction

    task automatic driveOp(input bit wide, input logic [15:0] a, input logic [15:0] b, input bit bin, input bit st);
        if (wide) begin
            start16 = st; a16 = a; b16 = b; bin16 = bin;
        end else begin
            start8 = st; a8 = a[7:0]; b8 = b[7:0]; bin8 = bin;
        end
    endtask

    task automatic sampleOut(input bit wide, output bit bsy, output bit dn, output logic [15:0] d,
                             output bit bo, output bit ov);
        if (wide) begin
            bsy = busy16; dn = done16; d = diff16; bo = bout16; ov = ovf16;
        end else begin
            bsy = busy8; dn = done8; d = {8'h00, diff8}; bo = bout8; ov = ovf8;
        end
    endtask

    // Pulses start for one cycle, optionally pokes start again mid-RUN, and
    // reports the cycle of the done pulse (0 on timeout) and the results there.
    task automatic applyStimulus(input bit wide, input logic [15:0] a, input logic [15:0] b, input bit bin,
                                 input bit noise, output int lat, output int busy_cnt,
                                 output logic [15:0] d, output bit bo, output bit ov);
        bit          bsy, dn, sbo, sov;
        logic [15:0] sd;
        @(negedge clk);
        driveOp(wide, a, b, bin, 1'b1);
        lat = 0; busy_cnt = 0; d = '0; bo = 1'b0; ov = 1'b0;
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            @(negedge clk);
            if (k == 1)
                driveOp(wide, a, b, bin, 1'b0);
            else if (noise && k == 3)
                driveOp(wide, 16'($urandom), 16'($urandom), 1'($urandom), 1'b1);
            else if (noise && k == 4)
                driveOp(wide, 16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
            sampleOut(wide, bsy, dn, sd, sbo, sov);
            if (bsy) busy_cnt++;
            if (dn) begin
                lat = k; d = sd; bo = sbo; ov = sov;
            end
        end
    endtask

    task automatic checkOp(input string name, input bit wide, input logic [15:0] a, input logic [15:0] b,
                           input bit bin, input bit noise, input logic [15:0] exp_d, input bit exp_bo,
                           input bit exp_ov);
        int          lat, busy_cnt, steps;
        logic [15:0] d;
        bit          bo, ov;
        steps = wide ? 4 : 8;
        applyStimulus(wide, a, b, bin, noise, lat, busy_cnt, d, bo, ov);
        checkOutput({name, ".latency"}, 16'(lat), 16'(steps + 1));
        checkOutput({name, ".busy_cycles"}, 16'(busy_cnt), 16'(steps));
        checkOutput({name, ".diff"}, d, exp_d);
        checkOutput({name, ".bout"}, 16'(bo), 16'(exp_bo));
        checkOutput({name, ".ovf"}, 16'(ov), 16'(exp_ov));
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [15:0] ra, rb, ed, d1, d2;
        bit          rbin, ebo, eov, rwide, busy_k10;
        int          first_done, second_done, done_cnt;

        rst_n = 1'b0;
        driveOp(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        driveOp(1'b1, 16'h0, 16'h0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("reset.busy8", 16'(busy8), 16'h0);
        checkOutput("reset.done8", 16'(done8), 16'h0);
        checkOutput("reset.diff8", 16'(diff8), 16'h0);
        checkOutput("reset.bout8", 16'(bout8), 16'h0);
        checkOutput("reset.ovf8", 16'(ovf8), 16'h0);
        checkOutput("reset.busy16", 16'(busy16), 16'h0);
        checkOutput("reset.diff16", diff16, 16'h0);
        rst_n = 1'b1;

        tbl[0] = '{1'b0, 16'h05, 16'h03, 1'b0, 16'h02, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 16'h03, 16'h05, 1'b0, 16'hFE, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 16'h80, 16'h01, 1'b0, 16'h7F, 1'b0, 1'b1};
        tbl[3] = '{1'b0, 16'h00, 16'h00, 1'b1, 16'hFF, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 16'h1234, 16'h0235, 1'b0, 16'h0FFF, 1'b0, 1'b0};
        foreach (tbl[i])
            checkOp($sformatf("table%0d", i), tbl[i].wide, tbl[i].a, tbl[i].b, tbl[i].bin, 1'b0,
                    tbl[i].d, tbl[i].bo, tbl[i].ov);

        // Back-to-back: start stays high through RUN and the DONE cycle.
        @(negedge clk);
        driveOp(1'b0, 16'h05, 16'h03, 1'b0, 1'b1);
        first_done = 0; second_done = 0; done_cnt = 0; d1 = '0; d2 = '0; busy_k10 = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == 1) driveOp(1'b0, 16'h10, 16'h01, 1'b0, 1'b1);
            if (k == 10) begin
                busy_k10 = busy8;
                start8   = 1'b0;
            end
            if (done8) begin
                done_cnt++;
                if (first_done == 0) begin
                    first_done = k; d1 = {8'h00, diff8};
                end else if (second_done == 0) begin
                    second_done = k; d2 = {8'h00, diff8};
                end
            end
        end
        checkOutput("b2b.first_done", 16'(first_done), 16'd9);
        checkOutput("b2b.first_diff", d1, 16'h02);
        checkOutput("b2b.busy_no_gap", 16'(busy_k10), 16'h1);
        checkOutput("b2b.second_done", 16'(second_done), 16'd18);
        checkOutput("b2b.second_diff", d2, 16'h0F);
        checkOutput("b2b.done_count", 16'(done_cnt), 16'd2);

        // Reset in the middle of RUN abandons the operation.
        checkOp("pre_reset", 1'b0, 16'h03, 16'h05, 1'b0, 1'b0, 16'hFE, 1'b1, 1'b0);
        @(negedge clk);
        driveOp(1'b0, 16'h80, 16'h01, 1'b0, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) start8 = 1'b0;
            if (k == 4) rst_n = 1'b0;
        end
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("midrst.busy", 16'(busy8), 16'h0);
        checkOutput("midrst.done", 16'(done8), 16'h0);
        checkOutput("midrst.diff", 16'(diff8), 16'h0);
        checkOutput("midrst.bout", 16'(bout8), 16'h0);
        checkOutput("midrst.ovf", 16'(ovf8), 16'h0);
        done_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done8) done_cnt++;
        end
        checkOutput("midrst.no_done", 16'(done_cnt), 16'h0);
        checkOp("post_reset", 1'b0, 16'h80, 16'h01, 1'b0, 1'b0, 16'h7F, 1'b0, 1'b1);

        // Random operands on both widths, with stray start pulses mid-RUN.
        for (int i = 0; i < 40; i++) begin
            rwide = (i % 3 == 0);
            ra    = 16'($urandom);
            rb    = 16'($urandom);
            rbin  = 1'($urandom);
            refModel(rwide, ra, rb, rbin, ed, ebo, eov);
            checkOp($sformatf("rand%0d", i), rwide, ra, rb, rbin, 1'(i % 2), ed, ebo, eov);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
